control_unity_ex_exmem: RTL and testbench
=========================================

CONTROL_UNITY_EX_EXMEM -- requirements
Module: control_unity_ex_exmem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction opcode, aligned with the operands below
- hazardMux  in  1  1 = insert bubble (force all control to 0)
- PC4  in  32  PC+4 of the instruction
- data1ALU  in  32  rs register data
- data2ALU  in  32  rt register data
- address  in  32  sign-extended immediate; bits [5:0] are funct
- reg2  in  5  rt field
- reg3  in  5  rd field
- outputShiftLeftOut  out  32  registered branch target
- outputALUOut  out  32  registered ALU result
- dataRegBank2Out  out  32  registered rt data (store data)
- muxRegDstOut  out  5  registered destination register
- BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut  out  1 each  registered control
- ZeroOut  out  1  registered ALU-zero flag

Function
REQ-003 The control decode SHALL be combinational from opcode, as {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}:
- 000000 R-type: 1,0,0,1,0,0,0,10
- 100011 lw: 0,1,1,1,1,0,0,00
- 101011 sw: 0,1,0,0,0,1,0,00
- 000100 beq: 0,0,0,0,0,0,1,01
- 001000 addi: 0,1,0,1,0,0,0,00
- any other opcode: all zero (NOP)
REQ-004 When hazardMux=1, all decoded control bits SHALL be 0, regardless of opcode.
REQ-005 ALU operand B SHALL be address when ALUSrc=1, else data2ALU; operand A SHALL be data1ALU.
REQ-006 The ALU operation SHALL be:
- ALUOp 00: add
- ALUOp 01: subtract
- ALUOp 11: result 0
- ALUOp 10, by funct: 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt (signed, result 1 or 0); any other funct gives result 0
REQ-007 Add and subtract SHALL be 32-bit modulo; overflow SHALL be ignored.
REQ-008 Zero SHALL be 1 exactly when the 32-bit ALU result equals 0.
REQ-009 The branch target SHALL be PC4 + (address << 2), modulo 2^32.
REQ-010 The destination register SHALL be reg3 when RegDst=1, else reg2.
REQ-011 On each rising clock edge with reset low, all outputs SHALL register the current-cycle values (branch target, ALU result, data2ALU, destination register, Branch, MemRead, MemWrite, MemtoReg, RegWrite, Zero), giving a latency of one cycle.
REQ-012 There SHALL be no stall or enable; the register SHALL load every cycle.
REQ-013 A bubble SHALL still register the datapath values (ALU result, target, register number), but with all control outputs at 0.

Reset
REQ-014 While reset=1, all outputs SHALL be 0, asynchronously, regardless of clock.
REQ-015 When reset is asserted mid-operation, the in-flight instruction SHALL be discarded.
REQ-016 The first rising edge after reset deasserts SHALL capture the current inputs normally.

Verification
REQ-017 R-type add: opcode=0, funct=100000, data1=5, data2=7, rt=2, rd=3 -> after one edge: ALUOut=12, muxRegDstOut=3, RegWriteOut=1, ZeroOut=0, other control 0.
REQ-018 lw: opcode=100011, data1=0x100, address=8, rt=4 -> ALUOut=0x108, muxRegDstOut=4, MemReadOut=1, MemtoRegOut=1, RegWriteOut=1.
REQ-019 beq taken: opcode=000100, data1=data2=9, PC4=0x40, address=3 -> ZeroOut=1, BranchOut=1, outputShiftLeftOut=0x4C; with data2=8 instead -> ZeroOut=0.
REQ-020 slt signed: funct=101010, data1=0xFFFFFFFF, data2=1 -> ALUOut=1; with operands swapped -> ALUOut=0, ZeroOut=1.
REQ-021 Bubble: sw with hazardMux=1 -> MemWriteOut=0 and all other control outputs 0.
REQ-022 Reset: assert reset between clock edges while outputs are nonzero -> all outputs 0 immediately, and they stay 0 across edges until reset is released.

Source files
------------

// File: rtl/control_unity_ex_exmem.sv
// control_unity_ex_exmem: opcode decode, EX-stage ALU and branch target, registered into the EX/MEM pipeline register.
module control_unity_ex_exmem (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        hazardMux,
    input  logic [31:0] PC4,
    input  logic [31:0] data1ALU,
    input  logic [31:0] data2ALU,
    input  logic [31:0] address,
    input  logic [4:0]  reg2,
    input  logic [4:0]  reg3,
    output logic [31:0] outputShiftLeftOut,
    output logic [31:0] outputALUOut,
    output logic [31:0] dataRegBank2Out,
    output logic [4:0]  muxRegDstOut,
    output logic        BranchOut,
    output logic        MemReadOut,
    output logic        MemWriteOut,
    output logic        MemtoRegOut,
    output logic        RegWriteOut,
    output logic        ZeroOut
);
    logic [8:0]  decoded;
    logic        regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch;
    logic [1:0]  aluOp;
    logic [31:0] operandB, aluResult, branchTarget;
    logic [5:0]  funct;

    always_comb begin
        decoded = 9'b0;
        case (opcode)
            6'b000000: decoded = 9'b1_0_0_1_0_0_0_10;
            6'b100011: decoded = 9'b0_1_1_1_1_0_0_00;
            6'b101011: decoded = 9'b0_1_0_0_0_1_0_00;
            6'b000100: decoded = 9'b0_0_0_0_0_0_1_01;
            6'b001000: decoded = 9'b0_1_0_1_0_0_0_00;
            default:   decoded = 9'b0;
        endcase
    end

    // A bubble clears control only; the datapath still computes with ALUOp=00.
    assign {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp} = hazardMux ? 9'b0 : decoded;

    assign funct        = address[5:0];
    assign operandB     = aluSrc ? address : data2ALU;
    assign branchTarget = PC4 + {address[29:0], 2'b00};

    always_comb begin
        aluResult = 32'b0;
        case (aluOp)
            2'b00: aluResult = data1ALU + operandB;
            2'b01: aluResult = data1ALU - operandB;
            2'b10: aluResult = funct == 6'b100000 ? data1ALU + operandB :
                               funct == 6'b100010 ? data1ALU - operandB :
                               funct == 6'b100100 ? data1ALU & operandB :
                               funct == 6'b100101 ? data1ALU | operandB :
                               funct == 6'b101010 ? {31'b0, $signed(data1ALU) < $signed(operandB)} : 32'b0;
            default: aluResult = 32'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outputShiftLeftOut <= 32'b0;
            outputALUOut       <= 32'b0;
            dataRegBank2Out    <= 32'b0;
            muxRegDstOut       <= 5'b0;
            BranchOut          <= 1'b0;
            MemReadOut         <= 1'b0;
            MemWriteOut        <= 1'b0;
            MemtoRegOut        <= 1'b0;
            RegWriteOut        <= 1'b0;
            ZeroOut            <= 1'b0;
        end else begin
            outputShiftLeftOut <= branchTarget;
            outputALUOut       <= aluResult;
            dataRegBank2Out    <= data2ALU;
            muxRegDstOut       <= regDst ? reg3 : reg2;
            BranchOut          <= branch;
            MemReadOut         <= memRead;
            MemWriteOut        <= memWrite;
            MemtoRegOut        <= memtoReg;
            RegWriteOut        <= regWrite;
            ZeroOut            <= aluResult == 32'b0;
        end
    end
endmodule

// File: tb/tb_control_unity_ex_exmem.sv
// tb_control_unity_ex_exmem: directed scoreboard bench for the EX stage and EX/MEM register.
module tb_control_unity_ex_exmem;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        hazardMux;
    logic [31:0] PC4, data1ALU, data2ALU, address;
    logic [4:0]  reg2, reg3;
    logic [31:0] outputShiftLeftOut, outputALUOut, dataRegBank2Out;
    logic [4:0]  muxRegDstOut;
    logic        BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut, ZeroOut;
    logic [106:0] allOut;

    typedef struct packed {
        logic [31:0] tgt, alu, d2;
        logic [4:0]  dst;
        logic        br, mr, mw, m2r, rw, z;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign allOut = {outputShiftLeftOut, outputALUOut, dataRegBank2Out, muxRegDstOut,
                     BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut, ZeroOut};

    control_unity_ex_exmem dut (
        .clock(clock), .reset(reset), .opcode(opcode), .hazardMux(hazardMux), .PC4(PC4),
        .data1ALU(data1ALU), .data2ALU(data2ALU), .address(address), .reg2(reg2), .reg3(reg3),
        .outputShiftLeftOut(outputShiftLeftOut), .outputALUOut(outputALUOut),
        .dataRegBank2Out(dataRegBank2Out), .muxRegDstOut(muxRegDstOut), .BranchOut(BranchOut),
        .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut), .MemtoRegOut(MemtoRegOut),
        .RegWriteOut(RegWriteOut), .ZeroOut(ZeroOut)
    );

    function automatic exp_t model(input logic [5:0] op, input logic hz, input logic [31:0] pc4,
                                   input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] addr,
                                   input logic [4:0] r2, input logic [4:0] r3);
        exp_t e;
        logic isR, isLw, isSw, isBeq, isAddi;
        logic [31:0] b, r;
        logic [5:0] f;
        isR    = !hz && op == 6'd0;
        isLw   = !hz && op == 6'h23;
        isSw   = !hz && op == 6'h2b;
        isBeq  = !hz && op == 6'h04;
        isAddi = !hz && op == 6'h08;
        f = addr[5:0];
        b = (isLw || isSw || isAddi) ? addr : d2;
        if (isR) begin
            if (f == 6'h20) r = d1 + b;
            else if (f == 6'h22) r = d1 - b;
            else if (f == 6'h24) r = d1 & b;
            else if (f == 6'h25) r = d1 | b;
            else if (f == 6'h2a) r = ($signed(d1) < $signed(b)) ? 32'd1 : 32'd0;
            else r = 32'd0;
        end else if (isBeq) r = d1 - b;
        else r = d1 + b;
        e.tgt = pc4 + (addr << 2);
        e.alu = r;
        e.d2  = d2;
        e.dst = isR ? r3 : r2;
        e.br  = isBeq;
        e.mr  = isLw;
        e.mw  = isSw;
        e.m2r = isLw;
        e.rw  = isR || isLw || isAddi;
        e.z   = r == 32'd0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one instruction from between edges, then compares after the capturing edge.
    task automatic step(input string tag, input logic [5:0] op, input logic hz, input logic [31:0] pc4,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] addr,
                        input logic [4:0] r2, input logic [4:0] r3);
        exp_t e;
        opcode = op; hazardMux = hz; PC4 = pc4; data1ALU = d1; data2ALU = d2;
        address = addr; reg2 = r2; reg3 = r3;
        sb.push_back(model(op, hz, pc4, d1, d2, addr, r2, r3));
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_tgt"}, outputShiftLeftOut, e.tgt);
            check({tag, "_alu"}, outputALUOut, e.alu);
            check({tag, "_d2"}, dataRegBank2Out, e.d2);
            check({tag, "_dst"}, muxRegDstOut, e.dst);
            check({tag, "_ctl"}, {BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut},
                  {e.br, e.mr, e.mw, e.m2r, e.rw});
            check({tag, "_zero"}, ZeroOut, e.z);
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'h23; hazardMux = 1'b0; PC4 = 32'h10; data1ALU = 32'h5; data2ALU = 32'h6;
        address = 32'h8; reg2 = 5'd1; reg3 = 5'd2;
        #12;
        check("reset_state", allOut, 0);
        @(posedge clock);
        #1;
        check("reset_hold", allOut, 0);
        reset = 1'b0;

        step("first_after_rst", 6'h23, 0, 32'h10, 32'h5, 32'h6, 32'h8, 5'd1, 5'd2);
        check("first_after_rst_alu", outputALUOut, 32'hD);

        step("r_add", 6'd0, 0, 32'h0, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
        check("r_add_alu_k", outputALUOut, 32'd12);
        check("r_add_dst_k", muxRegDstOut, 5'd3);
        check("r_add_ctl_k", {BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut, ZeroOut}, 6'b000010);

        step("lw", 6'h23, 0, 32'h0, 32'h100, 32'h0, 32'd8, 5'd4, 5'd9);
        check("lw_alu_k", outputALUOut, 32'h108);
        check("lw_ctl_k", {muxRegDstOut, MemReadOut, MemtoRegOut, RegWriteOut}, {5'd4, 3'b111});

        step("beq_taken", 6'h04, 0, 32'h40, 32'd9, 32'd9, 32'd3, 5'd1, 5'd2);
        check("beq_taken_k", {ZeroOut, BranchOut, outputShiftLeftOut}, {2'b11, 32'h4C});
        step("beq_not", 6'h04, 0, 32'h40, 32'd9, 32'd8, 32'd3, 5'd1, 5'd2);
        check("beq_not_zero_k", ZeroOut, 0);

        step("slt_neg", 6'd0, 0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd5, 5'd6);
        check("slt_neg_k", outputALUOut, 32'd1);
        step("slt_swap", 6'd0, 0, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd5, 5'd6);
        check("slt_swap_k", {outputALUOut, ZeroOut}, {32'd0, 1'b1});

        step("sw_bubble", 6'h2b, 1, 32'h8, 32'h20, 32'h33, 32'h4, 5'd7, 5'd8);
        check("sw_bubble_ctl_k", {BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut}, 0);
        check("sw_bubble_alu_k", outputALUOut, 32'h53);
        step("sw", 6'h2b, 0, 32'h8, 32'h20, 32'h33, 32'h4, 5'd7, 5'd8);
        check("sw_k", {MemWriteOut, outputALUOut, dataRegBank2Out}, {1'b1, 32'h24, 32'h33});

        step("r_sub", 6'd0, 0, 32'h0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd10);
        step("r_and", 6'd0, 0, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd11);
        step("r_or", 6'd0, 0, 32'h0, 32'hF0F0, 32'h0F00, 32'h25, 5'd1, 5'd12);
        step("r_badfunct", 6'd0, 0, 32'h0, 32'd3, 32'd5, 32'h3F, 5'd1, 5'd13);
        check("r_badfunct_k", {outputALUOut, ZeroOut}, {32'd0, 1'b1});
        step("add_ovf", 6'd0, 0, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 5'd1, 5'd14);
        check("add_ovf_k", outputALUOut, 32'h80000000);
        step("addi_neg", 6'h08, 0, 32'hFFFFFFF0, 32'd4, 32'd9, 32'hFFFFFFFC, 5'd15, 5'd16);
        check("addi_neg_k", {outputALUOut, outputShiftLeftOut, RegWriteOut}, {32'd0, 32'hFFFFFFE0, 1'b1});
        step("nop_op", 6'h3F, 0, 32'h4, 32'd2, 32'd3, 32'h20, 5'd17, 5'd18);
        check("nop_op_ctl_k", {BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut}, 0);

        for (int i = 0; i < 8; i++) begin
            logic [5:0] ops [6];
            ops = '{6'd0, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h11};
            step("rand", ops[$urandom_range(5)], 1'($urandom_range(1)), $urandom, $urandom, $urandom,
                 {$urandom_range(1) ? 26'd0 : 26'($urandom), 6'h20 + 6'($urandom_range(10))},
                 5'($urandom), 5'($urandom));
        end

        step("pre_rst", 6'h23, 0, 32'h100, 32'h100, 32'h1, 32'h8, 5'd4, 5'd9);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_async", allOut, 0);
        repeat (2) @(posedge clock);
        #1;
        check("mid_rst_hold", allOut, 0);
        reset = 1'b0;
        step("post_rst", 6'd0, 0, 32'h0, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
        check("post_rst_k", outputALUOut, 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
